// File: rtl/dct_pkg.sv
// Shared definitions for the DCT front end.
// Holds the DCT number format ({mant, exp}), the pixel level-shift and
// conversion exponent used when pixels enter the DCT domain, and the
// state encoding of the MCU scheduler's fetch FSM.
package dct_pkg;

  localparam int MANT_W    = 16;
  localparam int EXP_W     = 8;
  localparam int DCT_W     = MANT_W + EXP_W;

  // Pixels are unsigned 0..255; the DCT works on values centred on zero.
  localparam int LVL_SHIFT = 128;
  // mant = v << 8 with exp = 7 represents exactly v.
  localparam int CONV_EXP  = 7;

  typedef enum logic [1:0] {
    SCHED_IDLE    = 2'd0,
    SCHED_FETCH   = 2'd1,
    SCHED_RELEASE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/dct_prefetch_fifo.sv
// Synchronous prefetch FIFO between the MCU buffer fetcher and the DCT.
// Ports:
//   clk_in, rst          clock, asynchronous active-high reset
//   wr_en_i, wr_data_i   push one entry
//   rd_en_i              pop one entry (ignored while empty)
//   rd_data_o            head entry, combinational; 0 while empty
//   count_o              number of stored entries, 0..DEPTH
module dct_prefetch_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_wr, do_rd;

  assign do_rd = rd_en_i && (cnt_q != '0);
  // A full FIFO can still accept a push in a cycle that also pops.
  assign do_wr = wr_en_i && ((cnt_q != CW'(DEPTH)) || do_rd);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = (cnt_q == '0) ? '0 : mem[rd_ptr_q];
  assign count_o   = cnt_q;

endmodule

// File: rtl/dct_mcu_sched.sv
// MCU-to-DCT block scheduler.
// Fetches the 8-bit pixels of one MCU (BLOCKS_PER_MCU blocks of 64) from the
// producer's buffer, level-shifts them into the 24-bit DCT number format and
// queues them in a prefetch FIFO that the DCT pulls from.
// Ports:
//   clk_in, rst                 clock, asynchronous active-high reset
//   mcu_ready, mcu_last         producer: buffer full / last MCU of frame
//   mcu_release                 pulse: every sample of the MCU fetched
//   buf_rd, buf_addr, buf_data  buffer read port ({blk,row,col}, 1-cycle latency)
//   dct_valid, dct_rd, dct_d    DCT pull interface, dct_d = FIFO head
//   blk_start, blk_id           first-sample-of-block tag and block index
//   frame_done                  pulse on the final pop of the last MCU
//   underflow                   sticky: pop requested while FIFO empty
module dct_mcu_sched
  import dct_pkg::*;
#(
  parameter int BLOCKS_PER_MCU = 6,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              mcu_ready,
  input  logic              mcu_last,
  output logic              mcu_release,
  output logic              buf_rd,
  output logic [8:0]        buf_addr,
  input  logic [7:0]        buf_data,
  output logic              dct_valid,
  input  logic              dct_rd,
  output logic [DCT_W-1:0]  dct_d,
  output logic              blk_start,
  output logic [2:0]        blk_id,
  output logic              frame_done,
  output logic              underflow
);

  localparam int         CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0] LAST_ADDR = 9'(64 * BLOCKS_PER_MCU - 1);
  localparam logic [2:0] LAST_BLK  = 3'(BLOCKS_PER_MCU - 1);

  function automatic logic [DCT_W-1:0] to_dct(input logic [7:0] px);
    logic signed [7:0] v;
    v = signed'(px - 8'(LVL_SHIFT));
    return {v, {(MANT_W-8){1'b0}}, EXP_W'(CONV_EXP)};
  endfunction

  sched_state_t     state_q;
  logic [8:0]       fcnt_q;
  logic             last_q;
  logic             inflight_q;
  logic             last_fetched_q;
  logic [5:0]       pcnt_q;
  logic [2:0]       blk_q, blk_d;
  logic             underflow_q;

  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   occ;
  logic [DCT_W-1:0] conv_d;
  logic             pop, frame_tail, last_rd;

  dct_prefetch_fifo #(.DEPTH(FIFO_DEPTH), .W(DCT_W)) u_fifo (
    .clk_in    (clk_in),
    .rst       (rst),
    .wr_en_i   (inflight_q),
    .wr_data_i (conv_d),
    .rd_en_i   (dct_rd),
    .rd_data_o (dct_d),
    .count_o   (fifo_cnt)
  );

  // Buffer data returns one cycle after the read and is written straight in.
  assign conv_d = to_dct(buf_data);

  // A read still in flight owns a FIFO slot, so the FIFO can never overflow.
  assign occ      = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, inflight_q};
  assign buf_rd   = (state_q == SCHED_FETCH) && (occ < (CNT_W+1)'(FIFO_DEPTH));
  assign buf_addr = buf_rd ? fcnt_q : 9'd0;
  assign last_rd  = buf_rd && (fcnt_q == LAST_ADDR);

  assign mcu_release = (state_q == SCHED_RELEASE);

  // Fetch FSM.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= SCHED_IDLE;
      fcnt_q     <= '0;
      last_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= buf_rd;
      case (state_q)
        SCHED_IDLE: begin
          if (mcu_ready) begin
            state_q <= SCHED_FETCH;
            last_q  <= mcu_last;
            fcnt_q  <= '0;
          end
        end
        SCHED_FETCH: begin
          if (buf_rd) begin
            fcnt_q <= fcnt_q + 9'd1;
            if (last_rd) state_q <= SCHED_RELEASE;
          end
        end
        SCHED_RELEASE: begin
          if (mcu_ready && !last_q) begin
            state_q <= SCHED_FETCH;
            last_q  <= mcu_last;
            fcnt_q  <= '0;
          end else begin
            state_q <= SCHED_IDLE;
          end
        end
        default: state_q <= SCHED_IDLE;
      endcase
    end
  end

  // Once the frame's final read has completed, everything left is in the
  // FIFO and a short tail (< 8 samples) may still be offered to the DCT.
  assign frame_tail = last_q && (state_q != SCHED_FETCH) && !inflight_q;
  assign dct_valid  = (fifo_cnt >= CNT_W'(8)) || (frame_tail && (fifo_cnt != '0));

  assign pop        = dct_rd && (fifo_cnt != '0);
  assign blk_d      = (blk_q == LAST_BLK) ? 3'd0 : blk_q + 3'd1;
  assign blk_start  = pop && (pcnt_q == 6'd0);
  assign blk_id     = blk_q;
  // The FIFO is far shallower than an MCU, so once the frame's final sample
  // has been read, the next MCU-final pop can only be that sample.
  assign frame_done = pop && (pcnt_q == 6'd63) && (blk_q == LAST_BLK) && last_fetched_q;
  assign underflow  = underflow_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pcnt_q         <= '0;
      blk_q          <= '0;
      last_fetched_q <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (pop) begin
        pcnt_q <= pcnt_q + 6'd1;
        if (pcnt_q == 6'd63) blk_q <= blk_d;
      end
      if (last_rd && last_q) last_fetched_q <= 1'b1;
      else if (frame_done)   last_fetched_q <= 1'b0;
      if (dct_rd && (fifo_cnt == '0)) underflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dct_mcu_sched.sv
// Bench for dct_mcu_sched: a buffer model feeds pixels, expected DCT samples
// are queued as each read is answered and compared as the DCT pops them.
// A second, grayscale instance checks the single-block MCU.
`timescale 1ns/1ps
module tb_dct_mcu_sched;
  import dct_pkg::*;

  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  logic        mcu_ready, mcu_last, mcu_release, buf_rd;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_data;
  logic        dct_valid, dct_rd;
  logic [23:0] dct_d;
  logic        blk_start;
  logic [2:0]  blk_id;
  logic        frame_done, underflow;

  logic        g_mcu_ready, g_mcu_last, g_mcu_release, g_buf_rd;
  logic [8:0]  g_buf_addr;
  logic [7:0]  g_buf_data;
  logic        g_dct_valid, g_dct_rd;
  logic [23:0] g_dct_d;
  logic        g_blk_start;
  logic [2:0]  g_blk_id;
  logic        g_frame_done, g_underflow;

  dct_mcu_sched #(.BLOCKS_PER_MCU(6), .FIFO_DEPTH(16)) dut (
    .clk_in(clk_in), .rst(rst), .mcu_ready(mcu_ready), .mcu_last(mcu_last),
    .mcu_release(mcu_release), .buf_rd(buf_rd), .buf_addr(buf_addr),
    .buf_data(buf_data), .dct_valid(dct_valid), .dct_rd(dct_rd), .dct_d(dct_d),
    .blk_start(blk_start), .blk_id(blk_id), .frame_done(frame_done),
    .underflow(underflow)
  );

  dct_mcu_sched #(.BLOCKS_PER_MCU(1), .FIFO_DEPTH(16)) gdut (
    .clk_in(clk_in), .rst(rst), .mcu_ready(g_mcu_ready), .mcu_last(g_mcu_last),
    .mcu_release(g_mcu_release), .buf_rd(g_buf_rd), .buf_addr(g_buf_addr),
    .buf_data(g_buf_data), .dct_valid(g_dct_valid), .dct_rd(g_dct_rd),
    .dct_d(g_dct_d), .blk_start(g_blk_start), .blk_id(g_blk_id),
    .frame_done(g_frame_done), .underflow(g_underflow)
  );

  logic [17:0] ctrl_vec;
  assign ctrl_vec = {mcu_release, buf_rd, buf_addr, dct_valid, blk_start,
                     blk_id, frame_done, underflow};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pixels 0,1,2 of every MCU are the conversion corner cases.
  function automatic logic [7:0] pix(input logic [8:0] a);
    case (a)
      9'd0:    return 8'd0;
      9'd1:    return 8'd128;
      9'd2:    return 8'd255;
      default: return 8'((int'(a) * 7 + 13) & 255);
    endcase
  endfunction

  function automatic logic [23:0] conv(input logic [7:0] p);
    int v;
    v = int'(p) - 128;
    return {8'(v), 8'h00, 8'h07};
  endfunction

  logic [23:0] exp_q[$];
  logic [7:0]  pend, g_pend;
  int exp_addr = 0, n_rd = 0, n_rel = 0, n_blk = 0, n_frame = 0;
  int fpops = 0, exp_blk = 0, frame_mcus = 1;
  int prev_addr = 0, g_prev_addr = 0, g_rel = 0, g_frame = 0, g_blk = 0;
  bit prev_rd = 0, g_prev_rd = 0, chk_pop = 1;

  // Buffer model and output monitor, all on the falling edge.
  initial begin
    buf_data = 8'd0; g_buf_data = 8'd0; pend = 8'd0; g_pend = 8'd0;
    forever begin
      @(negedge clk_in);
      buf_data   = pend;
      g_buf_data = g_pend;
      if (mcu_release) begin
        check("release_after_last_rd", prev_rd ? prev_addr : -1, 383);
        n_rel++;
        exp_addr = 0;
      end
      if (buf_rd) begin
        check("buf_addr", buf_addr, exp_addr);
        exp_addr++;
        n_rd++;
        pend = pix(buf_addr);
        exp_q.push_back(conv(pend));
      end
      prev_rd   = buf_rd;
      prev_addr = int'(buf_addr);
      if (dct_rd && chk_pop) begin
        if (exp_q.size() == 0) check("pop_with_empty_scoreboard", 0, 1);
        else check("dct_d", dct_d, exp_q.pop_front());
        fpops++;
      end
      if (blk_start) begin
        check("blk_id", blk_id, exp_blk);
        check("valid_at_blk_start", dct_valid, 1);
        exp_blk = (exp_blk + 1) % 6;
        n_blk++;
      end
      if (frame_done) begin
        check("frame_done_pop", fpops, 384 * frame_mcus);
        fpops = 0;
        n_frame++;
      end
      if (g_mcu_release) begin
        check("g_release_after_last_rd", g_prev_rd ? g_prev_addr : -1, 63);
        g_rel++;
      end
      if (g_buf_rd) g_pend = pix(g_buf_addr);
      g_prev_rd   = g_buf_rd;
      g_prev_addr = int'(g_buf_addr);
      if (g_blk_start) begin
        check("g_blk_id", g_blk_id, 0);
        g_blk++;
      end
      if (g_frame_done) g_frame++;
    end
  end

  // DCT model: at each block boundary wait for valid, then 8 bursts of 8.
  task automatic dct_pull(input int nbursts, input int gap);
    for (int b = 0; b < nbursts; b++) begin
      repeat (gap) @(negedge clk_in);
      if (b % 8 == 0) begin
        int t = 0;
        while (!dct_valid && t < 5000) begin
          @(negedge clk_in);
          t++;
        end
        if (!dct_valid) begin
          check("dct_valid_timeout", dct_valid, 1);
          return;
        end
      end
      @(posedge clk_in); #1 dct_rd = 1'b1;
      repeat (8) @(posedge clk_in);
      #1 dct_rd = 1'b0;
    end
  endtask

  initial begin
    int t, r0, f0, b0, rd0;
    logic [23:0] tbl [3];
    tbl = '{24'h800007, 24'h000007, 24'h7F0007};
    rst = 1'b1; mcu_ready = 1'b0; mcu_last = 1'b0; dct_rd = 1'b0;
    g_mcu_ready = 1'b0; g_mcu_last = 1'b0; g_dct_rd = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_ctrl", ctrl_vec, 0);
    check("rst_dct_d", dct_d, 0);
    @(posedge clk_in); #1 rst = 1'b0;
    repeat (3) @(negedge clk_in);
    check("idle_ctrl", ctrl_vec, 0);

    // Abort a fetch with reset at address 100
    frame_mcus = 1;
    @(posedge clk_in); #1 mcu_ready = 1'b1; mcu_last = 1'b1;
    @(posedge clk_in); #1 mcu_ready = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_in);
      if (buf_rd && buf_addr == 9'd100) break;
      @(posedge clk_in); #1 dct_rd = dct_valid;
    end
    check("abort_reached_addr100", {buf_rd, buf_addr}, {1'b1, 9'd100});
    #1 rst = 1'b1; dct_rd = 1'b0;
    #1;
    check("abort_buf_rd", buf_rd, 0);
    check("abort_fifo_cnt", dut.fifo_cnt, 0);
    check("abort_dct_valid", dct_valid, 0);
    check("abort_dct_d", dct_d, 0);
    exp_q.delete(); exp_addr = 0; exp_blk = 0; fpops = 0;
    @(posedge clk_in); @(posedge clk_in); #1 rst = 1'b0;
    @(negedge clk_in);
    check("abort_state_idle", dut.state_q, SCHED_IDLE);
    check("abort_no_rd", buf_rd, 0);

    // Backpressure, conversion corner cases, then drain at 1 pop/cycle
    rd0 = n_rd; r0 = n_rel; f0 = n_frame;
    @(posedge clk_in); #1 mcu_ready = 1'b1; mcu_last = 1'b1;
    @(posedge clk_in); #1 mcu_ready = 1'b0; mcu_last = 1'b0;
    repeat (30) @(negedge clk_in);
    check("bp_reads", n_rd - rd0, 16);
    check("bp_buf_rd", buf_rd, 0);
    check("bp_fifo_cnt", dut.fifo_cnt, 16);
    check("bp_dct_valid", dct_valid, 1);
    for (int i = 0; i < 384; i++) begin
      @(posedge clk_in); #1 dct_rd = 1'b1;
      @(negedge clk_in);
      if (i < 3) check("conv_corner", dct_d, tbl[i]);
    end
    @(posedge clk_in); #1 dct_rd = 1'b0;
    repeat (3) @(negedge clk_in);
    check("bp_total_reads", n_rd - rd0, 384);
    check("bp_releases", n_rel - r0, 1);
    check("bp_frame_done", n_frame - f0, 1);
    check("bp_scoreboard_empty", exp_q.size(), 0);
    check("bp_no_underflow", underflow, 0);

    // One MCU with the DCT pulling a burst every 64 cycles
    rd0 = n_rd; r0 = n_rel; f0 = n_frame; b0 = n_blk;
    @(posedge clk_in); #1 mcu_ready = 1'b1; mcu_last = 1'b1;
    @(posedge clk_in); #1 mcu_ready = 1'b0; mcu_last = 1'b0;
    dct_pull(48, 64);
    repeat (4) @(negedge clk_in);
    check("mcu_reads", n_rd - rd0, 384);
    check("mcu_releases", n_rel - r0, 1);
    check("mcu_blk_starts", n_blk - b0, 6);
    check("mcu_frame_done", n_frame - f0, 1);
    check("mcu_scoreboard_empty", exp_q.size(), 0);
    check("mcu_blk_id_wrapped", blk_id, 0);

    // Two MCUs back to back
    rd0 = n_rd; r0 = n_rel; f0 = n_frame; b0 = n_blk;
    frame_mcus = 2;
    fork
      dct_pull(96, 16);
      begin
        @(posedge clk_in); #1 mcu_ready = 1'b1; mcu_last = 1'b0;
        t = 0;
        while (!mcu_release && t < 10000) begin
          @(negedge clk_in);
          t++;
        end
        check("b2b_first_release_seen", mcu_release, 1);
        mcu_last = 1'b1;
        @(negedge clk_in);
        check("b2b_release_to_fetch", dut.state_q, SCHED_FETCH);
        mcu_ready = 1'b0; mcu_last = 1'b0;
      end
    join
    repeat (4) @(negedge clk_in);
    check("b2b_reads", n_rd - rd0, 768);
    check("b2b_releases", n_rel - r0, 2);
    check("b2b_blk_starts", n_blk - b0, 12);
    check("b2b_frame_done_once", n_frame - f0, 1);
    check("b2b_scoreboard_empty", exp_q.size(), 0);

    // Illegal pop on an empty FIFO
    chk_pop = 0;
    @(posedge clk_in); #1 dct_rd = 1'b1;
    @(negedge clk_in);
    check("uf_dct_d_zero", dct_d, 0);
    @(posedge clk_in); #1 dct_rd = 1'b0;
    @(negedge clk_in);
    check("uf_set", underflow, 1);
    check("uf_fifo_cnt", dut.fifo_cnt, 0);
    repeat (3) @(negedge clk_in);
    check("uf_sticky", underflow, 1);
    check("uf_fifo_cnt_hold", dut.fifo_cnt, 0);
    check("uf_no_valid", dct_valid, 0);

    // Grayscale instance: one block per MCU
    @(posedge clk_in); #1 g_mcu_ready = 1'b1; g_mcu_last = 1'b1;
    @(posedge clk_in); #1 g_mcu_ready = 1'b0; g_mcu_last = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk_in); #1 g_dct_rd = g_dct_valid;
      @(negedge clk_in);
    end
    @(posedge clk_in); #1 g_dct_rd = 1'b0;
    repeat (2) @(negedge clk_in);
    check("g_releases", g_rel, 1);
    check("g_blk_starts", g_blk, 1);
    check("g_frame_done", g_frame, 1);
    check("g_no_underflow", g_underflow, 0);
    check("g_fifo_drained", gdut.fifo_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
